cook_timer: RTL and testbench



---
 rtl/cook_timer_pkg.sv | 13 +
 rtl/cook_timer_bcd_digit_down.sv | 25 ++
 rtl/cook_timer.sv | 126 ++++++++++++
 tb/tb_cook_timer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cook_timer_pkg.sv
// rtl/cook_timer_pkg.sv - shared BCD types, constants and helpers for cook_timer
package cook_timer_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX       = 4'd9;
    localparam bcd_digit_t SEC_TENS_WRAP = 4'd5;

    function automatic logic is_zero_time(input logic [15:0] t);
        return (t == 16'h0000);
    endfunction

endpackage

// File: rtl/cook_timer_bcd_digit_down.sv
// rtl/cook_timer_bcd_digit_down.sv - one BCD digit of a borrow-chained down counter
module bcd_digit_down
    import cook_timer_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       borrow_in,
    input  bcd_digit_t wrap_val,
    output bcd_digit_t digit_next,
    output logic       borrow_out
);

    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_next = wrap_val;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/cook_timer.sv
// rtl/cook_timer.sv - BCD MM:SS cook countdown timer; optional done beep via COOK_TIMER_BEEP_EN
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int BEEP_CYCLES   = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        clearn,
    input  logic        mag_on,
    output logic [15:0] time_bcd,
    output logic        timer_done,
    output logic        done_beep
);

    localparam int PW = $clog2(TICKS_PER_SEC);

    generate
        if (TICKS_PER_SEC < 2 || BEEP_CYCLES < 1) begin : g_param_check
            $error("cook_timer: TICKS_PER_SEC must be >= 2 and BEEP_CYCLES >= 1");
        end
    endgenerate

    logic [PW-1:0] prescaler;
    logic [15:0]   time_dec;
    logic [3:0]    borrow;
    logic          time_zero;
    logic          tick;

    assign time_zero = is_zero_time(time_bcd);
    assign tick      = mag_on && !time_zero && (prescaler == PW'(TICKS_PER_SEC - 1));

    // Digits from sec_ones upward; the seconds-ones digit always borrows one.
    bcd_digit_down u_sec_ones (
        .digit      (time_bcd[3:0]),
        .borrow_in  (1'b1),
        .wrap_val   (BCD_MAX),
        .digit_next (time_dec[3:0]),
        .borrow_out (borrow[0])
    );

    bcd_digit_down u_sec_tens (
        .digit      (time_bcd[7:4]),
        .borrow_in  (borrow[0]),
        .wrap_val   (SEC_TENS_WRAP),
        .digit_next (time_dec[7:4]),
        .borrow_out (borrow[1])
    );

    bcd_digit_down u_min_ones (
        .digit      (time_bcd[11:8]),
        .borrow_in  (borrow[1]),
        .wrap_val   (BCD_MAX),
        .digit_next (time_dec[11:8]),
        .borrow_out (borrow[2])
    );

    bcd_digit_down u_min_tens (
        .digit      (time_bcd[15:12]),
        .borrow_in  (borrow[2]),
        .wrap_val   (BCD_MAX),
        .digit_next (time_dec[15:12]),
        .borrow_out (borrow[3])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            time_bcd  <= 16'h0000;
            prescaler <= '0;
        end else if (!clearn) begin
            time_bcd  <= 16'h0000;
            prescaler <= '0;
        end else if (mag_on) begin
            if (time_zero) begin
                prescaler <= '0;
            end else if (tick) begin
                time_bcd  <= time_dec;
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end else begin
            // Idle: prescaler held at 0 so a resumed cook runs a full second first.
            prescaler <= '0;
            if (key_valid && (key_digit <= BCD_MAX)) begin
                time_bcd <= {time_bcd[11:0], key_digit};
            end
        end
    end

    assign timer_done = time_zero;

`ifdef COOK_TIMER_BEEP_EN
    localparam int BW = $clog2(BEEP_CYCLES + 1);

    logic [BW-1:0] beep_cnt;
    logic          beep_active;

    always_ff @(posedge clk) begin
        if (rst || !clearn) begin
            beep_cnt    <= '0;
            beep_active <= 1'b0;
        end else if (tick && (time_bcd == 16'h0001)) begin
            beep_cnt    <= BW'(BEEP_CYCLES - 1);
            beep_active <= 1'b1;
        end else if (beep_active) begin
            if (beep_cnt == '0) begin
                beep_active <= 1'b0;
            end else begin
                beep_cnt <= beep_cnt - BW'(1);
            end
        end
    end

    assign done_beep = beep_active;
`else
    assign done_beep = 1'b0;
`endif

    logic unused_borrow;
    assign unused_borrow = borrow[3];

endmodule

// File: tb/tb_cook_timer.sv
// tb/tb_cook_timer.sv - directed self-checking bench for cook_timer
module tb_cook_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        clearn;
    logic        mag_on;
    logic [15:0] time_bcd;
    logic        timer_done;
    logic        done_beep;

    int total = 0;
    int bad   = 0;

`ifdef COOK_TIMER_BEEP_EN
    localparam logic BEEP_ON = 1'b1;
`else
    localparam logic BEEP_ON = 1'b0;
`endif

    cook_timer #(
        .TICKS_PER_SEC (4),
        .BEEP_CYCLES   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .clearn     (clearn),
        .mag_on     (mag_on),
        .time_bcd   (time_bcd),
        .timer_done (timer_done),
        .done_beep  (done_beep)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick(1);
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic load(input logic [15:0] t);
        key(t[15:12]);
        key(t[11:8]);
        key(t[7:4]);
        key(t[3:0]);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; clearn = 1'b1; mag_on = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        @(posedge clk); #1;
        tick(2);
        rst = 1'b0;
        chk("reset_time", time_bcd, 16'h0000);
        chk("reset_done", {15'd0, timer_done}, 16'd1);
        chk("reset_beep", {15'd0, done_beep}, 16'd0);

        key(4'd1);
        chk("key_1", time_bcd, 16'h0001);
        key(4'd3);
        key(4'd0);
        chk("key_130", time_bcd, 16'h0130);
        chk("key_done_low", {15'd0, timer_done}, 16'd0);
        key(4'hB);
        chk("key_illegal", time_bcd, 16'h0130);

        load(16'h0100);
        chk("load_0100", time_bcd, 16'h0100);
        mag_on = 1'b1;
        tick(3);
        chk("latency_3", time_bcd, 16'h0100);
        tick(1);
        chk("dec_0100", time_bcd, 16'h0059);
        mag_on = 1'b0;

        load(16'h0099);
        mag_on = 1'b1;
        tick(4);
        chk("dec_0099", time_bcd, 16'h0098);
        mag_on = 1'b0;

        load(16'h1000);
        mag_on = 1'b1;
        tick(4);
        chk("dec_1000", time_bcd, 16'h0959);
        mag_on = 1'b0;

        load(16'h0002);
        mag_on = 1'b1;
        tick(4);
        chk("run_0001", time_bcd, 16'h0001);
        chk("beep_before", {15'd0, done_beep}, 16'd0);
        tick(4);
        chk("run_0000", time_bcd, 16'h0000);
        chk("run_done", {15'd0, timer_done}, 16'd1);
        chk("beep_c1", {15'd0, done_beep}, {15'd0, BEEP_ON});
        tick(2);
        chk("beep_c3", {15'd0, done_beep}, {15'd0, BEEP_ON});
        tick(1);
        chk("beep_end", {15'd0, done_beep}, 16'd0);
        tick(1);
        chk("no_wrap", time_bcd, 16'h0000);
        mag_on = 1'b0;

        load(16'h0005);
        mag_on = 1'b1;
        tick(2);
        mag_on = 1'b0;
        tick(1);
        mag_on = 1'b1;
        tick(3);
        chk("pause_hold", time_bcd, 16'h0005);
        tick(1);
        chk("pause_dec", time_bcd, 16'h0004);
        key(4'd7);
        chk("key_lockout", time_bcd, 16'h0004);
        mag_on = 1'b0;

        load(16'h0327);
        mag_on = 1'b1;
        tick(2);
        clearn = 1'b0;
        tick(1);
        clearn = 1'b1;
        chk("clear_time", time_bcd, 16'h0000);
        chk("clear_done", {15'd0, timer_done}, 16'd1);
        chk("clear_beep", {15'd0, done_beep}, 16'd0);
        tick(4);
        chk("clear_hold", time_bcd, 16'h0000);
        chk("clear_no_beep", {15'd0, done_beep}, 16'd0);
        mag_on = 1'b0;

        load(16'h0001);
        mag_on = 1'b1;
        tick(4);
        chk("abort_start", {15'd0, done_beep}, {15'd0, BEEP_ON});
        clearn = 1'b0;
        tick(1);
        clearn = 1'b1;
        chk("abort_beep", {15'd0, done_beep}, 16'd0);
        mag_on = 1'b0;

        load(16'h0327);
        mag_on = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_time", time_bcd, 16'h0000);
        chk("rst_done", {15'd0, timer_done}, 16'd1);
        chk("rst_beep", {15'd0, done_beep}, 16'd0);
        mag_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
